ui_uart_tx: RTL and testbench

//   Serial UART transmitter (8 data bits, optional parity, 1 or 2 stop bits, LSB first).

---
 rtl/ui_uart_tx.sv | 173 +++++++++++++++++
 tb/tb_ui_uart_tx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ui_uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional odd/even parity, 1 or 2 stop bits.
// Bit timing comes from an internal baud counter; all outputs are registered.
module ui_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_data_val,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       tx_busy,
    output logic       txd
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

    generate
        if ((PARITY < 0) || (PARITY > 2) || (STOP_BITS < 1) || (STOP_BITS > 2) ||
            (CLKS_PER_BIT < 4)) begin : g_bad_params
            $fatal(1, "ui_uart_tx: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic              stop_q, stop_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              par_q, par_d;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              baud_end_s;

    function automatic logic calc_parity(input logic [7:0] d);
        return (PARITY == 1) ? ~^d : ^d;
    endfunction

    assign baud_end_s = (baud_q == BAUD_LAST);

    // Next-state logic; txd_d is computed for the state being entered so txd is registered.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + BAUD_W'(1);
        bit_d   = bit_q;
        stop_d  = stop_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        txd_d   = txd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (tx_data_val) begin
                    shreg_d = tx_data;
                    par_d   = calc_parity(tx_data);
                    state_d = S_START;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    txd_d  = 1'b1;
                    busy_d = 1'b0;
                end
            end
            S_START: begin
                if (baud_end_s) begin
                    state_d = S_DATA;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    txd_d   = shreg_q[0];
                end else begin
                    txd_d = 1'b0;
                end
            end
            S_DATA: begin
                if (baud_end_s) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            txd_d   = par_q;
                        end else begin
                            state_d = S_STOP;
                            stop_d  = 1'b0;
                            txd_d   = 1'b1;
                            done_d  = 1'b1;
                        end
                    end else begin
                        shreg_d = {1'b0, shreg_q[7:1]};
                        txd_d   = shreg_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    txd_d = shreg_q[0];
                end
            end
            S_PARITY: begin
                if (baud_end_s) begin
                    state_d = S_STOP;
                    baud_d  = '0;
                    stop_d  = 1'b0;
                    txd_d   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    txd_d = par_q;
                end
            end
            S_STOP: begin
                txd_d = 1'b1;
                if (baud_end_s) begin
                    baud_d = '0;
                    if (stop_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end else begin
                    stop_d = stop_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counter and output registers; reset abandons any frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            stop_q  <= 1'b0;
            shreg_q <= 8'h00;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign txd     = txd_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_ui_uart_tx.sv
// Directed bench for ui_uart_tx: four instances cover no parity, even, odd and two stop bits.
// Expected characters are queued by the driver and popped by the frame monitor.
module tb_ui_uart_tx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] val_v;
    logic [7:0] data_a [4];
    logic [3:0] txd_v, busy_v, done_v;

    int         pass_cnt  = 0;
    int         total_cnt = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    ui_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u_p0 (
        .clk(clk), .rst(rst), .tx_data_val(val_v[0]), .tx_data(data_a[0]),
        .tx_done(done_v[0]), .tx_busy(busy_v[0]), .txd(txd_v[0]));
    ui_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) u_even (
        .clk(clk), .rst(rst), .tx_data_val(val_v[1]), .tx_data(data_a[1]),
        .tx_done(done_v[1]), .tx_busy(busy_v[1]), .txd(txd_v[1]));
    ui_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) u_odd (
        .clk(clk), .rst(rst), .tx_data_val(val_v[2]), .tx_data(data_a[2]),
        .tx_done(done_v[2]), .tx_busy(busy_v[2]), .txd(txd_v[2]));
    ui_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(2)) u_stop2 (
        .clk(clk), .rst(rst), .tx_data_val(val_v[3]), .tx_data(data_a[3]),
        .tx_done(done_v[3]), .tx_busy(busy_v[3]), .txd(txd_v[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Upstream model: hold valid until tx_done, then drop it after `hold` cycles.
    task automatic drive(input int k, input logic [7:0] b, input int hold, input int chg_at);
        int n;
        exp_q.push_back(b);
        @(negedge clk);
        data_a[k] = b;
        val_v[k]  = 1'b1;
        n = 0;
        while (done_v[k] !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
            if (n == chg_at) data_a[k] = ~b;
        end
        repeat (hold) @(negedge clk);
        val_v[k] = 1'b0;
    endtask

    // Frame monitor: checks every txd cycle, done position, busy length against the popped byte.
    task automatic check_frame(input int k, input int par, input int nstop, output int waited);
        logic [7:0] exp_b, got;
        logic       exp_par, par_b, exp_bit;
        int         len, done_cnt, done_at, busy_cnt, bad, bi;
        waited = 0; got = 8'h00; par_b = 1'b0;
        done_cnt = 0; done_at = -1; busy_cnt = 0; bad = 0;
        while (txd_v[k] !== 1'b0 && waited < 4000) begin
            @(negedge clk);
            waited++;
        end
        chk("start_seen", 32'(txd_v[k]), 32'd0);
        if (exp_q.size() > 0) exp_b = exp_q.pop_front();
        else exp_b = 8'hxx;
        exp_par = (par == 1) ? ~^exp_b : ^exp_b;
        len = (10 + ((par != 0) ? 1 : 0) + (nstop - 1)) * CPB;
        for (int c = 0; c < len; c++) begin
            bi = c / CPB;
            if (bi == 0) exp_bit = 1'b0;
            else if (bi <= 8) exp_bit = exp_b[bi-1];
            else if (par != 0 && bi == 9) exp_bit = exp_par;
            else exp_bit = 1'b1;
            if (txd_v[k] !== exp_bit) bad++;
            if (c % CPB == CPB / 2) begin
                if (bi >= 1 && bi <= 8) got[bi-1] = txd_v[k];
                if (par != 0 && bi == 9) par_b = txd_v[k];
            end
            if (done_v[k] === 1'b1) begin
                done_cnt++;
                done_at = c;
            end
            if (busy_v[k] === 1'b1) busy_cnt++;
            @(negedge clk);
        end
        chk("data_byte", 32'(got), 32'(exp_b));
        if (par != 0) chk("parity_bit", 32'(par_b), 32'(exp_par));
        chk("txd_cycle_errors", 32'(bad), 32'd0);
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("done_at", 32'(done_at), 32'((9 + ((par != 0) ? 1 : 0)) * CPB));
        chk("busy_len", 32'(busy_cnt), 32'(len));
        chk("busy_drop", 32'(busy_v[k]), 32'd0);
        chk("txd_idle", 32'(txd_v[k]), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, w2, n, cnt;
        val_v = 4'h0;
        for (int i = 0; i < 4; i++) data_a[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_txd", 32'(txd_v), 32'hF);
        chk("rst_busy", 32'(busy_v), 32'h0);
        chk("rst_done", 32'(done_v), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 0x55, no parity, one stop bit
        fork
            drive(0, 8'h55, 1, 0);
            check_frame(0, 0, 1, w);
        join

        // even and odd parity on 0x07, two stop bits on 0xA3
        fork
            drive(1, 8'h07, 1, 0);
            check_frame(1, 2, 1, w);
        join
        fork
            drive(2, 8'h07, 1, 0);
            check_frame(2, 1, 1, w);
        join
        fork
            drive(3, 8'hA3, 1, 0);
            check_frame(3, 0, 2, w);
        join

        // back-to-back 0x00 then 0xFF: one idle cycle between frames
        fork
            begin
                drive(0, 8'h00, 1, 0);
                drive(0, 8'hFF, 1, 0);
            end
            begin
                check_frame(0, 0, 1, w);
                check_frame(0, 0, 1, w2);
                chk("b2b_gap", 32'(w2), 32'd1);
            end
        join

        // data changes mid-frame and valid held 2 cycles past tx_done
        fork
            drive(0, 8'h96, 2, 50);
            check_frame(0, 0, 1, w);
        join
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy_v[0] === 1'b1) cnt++;
        end
        chk("no_refire", 32'(cnt), 32'd0);

        // reset in data bit 3 of 0xC3
        @(negedge clk);
        data_a[0] = 8'hC3;
        val_v[0]  = 1'b1;
        n = 0;
        while (txd_v[0] !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        cnt = 0;
        repeat (72) begin
            @(negedge clk);
            if (done_v[0] === 1'b1) cnt++;
        end
        chk("pre_rst_txd", 32'(txd_v[0]), 32'd0);
        chk("pre_rst_busy", 32'(busy_v[0]), 32'd1);
        #2;
        rst = 1'b1;
        val_v[0] = 1'b0;
        #1;
        chk("async_rst_txd", 32'(txd_v[0]), 32'd1);
        chk("async_rst_busy", 32'(busy_v[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done_v[0] === 1'b1) cnt++;
        end
        chk("rst_no_done", 32'(cnt), 32'd0);
        fork
            drive(0, 8'h3C, 1, 0);
            check_frame(0, 0, 1, w);
        join
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
